// File: rtl/bcd_convert_arbiter.sv
// Shared sequential binary-to-BCD converter (shift-and-add-3, one shift per clock)
// with round-robin arbitration among NUM_REQ requesters and a req/ack handshake.
module bcd_convert_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   number,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   valid,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic [3:0]             hundreds,
    output logic [3:0]             tens,
    output logic [3:0]             ones
);

    localparam int unsigned SH_W  = 20;
    localparam int unsigned CNT_W = 3;

    typedef enum logic {IDLE, CONV} state_t;

    state_t               state;
    logic [SH_W-1:0]      shift_q;
    logic [CNT_W-1:0]     count;
    logic [ID_W-1:0]      last;

    logic [NUM_REQ-1:0]   eligible;
    logic [2*NUM_REQ-1:0] elig_dbl;
    logic [2*NUM_REQ-1:0] elig_rot;
    logic                 win_found;
    int unsigned          win_off;
    logic [ID_W-1:0]      win_id;
    logic [7:0]           win_operand;
    logic [SH_W-1:0]      adj;
    logic [SH_W-1:0]      shifted;

    // Round-robin pick: rotate so that bit 0 is requester last+1, take the first set bit.
    always_comb begin
        eligible  = req & ~ack;
        elig_dbl  = {eligible, eligible};
        elig_rot  = elig_dbl >> (32'(last) + 32'd1);
        win_found = 1'b0;
        win_off   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && elig_rot[i]) begin
                win_found = 1'b1;
                win_off   = i;
            end
        end
        win_id      = ID_W'((32'(last) + 32'd1 + win_off) % NUM_REQ);
        win_operand = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_id) begin
                win_operand = number[8*i +: 8];
            end
        end
    end

    // Add-3 correction on each BCD nibble, then the single left shift of this edge.
    always_comb begin
        adj        = shift_q;
        adj[11:8]  = (shift_q[11:8]  >= 4'd5) ? shift_q[11:8]  + 4'd3 : shift_q[11:8];
        adj[15:12] = (shift_q[15:12] >= 4'd5) ? shift_q[15:12] + 4'd3 : shift_q[15:12];
        adj[19:16] = (shift_q[19:16] >= 4'd5) ? shift_q[19:16] + 4'd3 : shift_q[19:16];
        shifted    = {adj[SH_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift_q  <= '0;
            count    <= '0;
            last     <= ID_W'(NUM_REQ - 1);
            ack      <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
        end else begin
            ack   <= '0;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    // The ack cycle is not an arbitration cycle; the next grant waits one more edge.
                    if (win_found && !valid) begin
                        shift_q  <= {12'd0, win_operand};
                        count    <= '0;
                        grant_id <= win_id;
                        last     <= win_id;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shifted;
                    count   <= count + CNT_W'(1);
                    if (count == CNT_W'(7)) begin
                        hundreds <= shifted[19:16];
                        tens     <= shifted[15:12];
                        ones     <= shifted[11:8];
                        ack      <= NUM_REQ'(1) << grant_id;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed self-checking bench for bcd_convert_arbiter: latency, RR order, digit sweep,
// reset abort and post-capture operand changes.
module tb_bcd_convert_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] number;
    logic [1:0]  ack;
    logic        valid;
    logic        busy;
    logic [1:0]  grant_id;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;

    int checks   = 0;
    int failures = 0;

    bcd_convert_arbiter #(.NUM_REQ(2), .ID_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .number   (number),
        .ack      (ack),
        .valid    (valid),
        .busy     (busy),
        .grant_id (grant_id),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick until ack rises (bounded); returns the number of ticks taken, 0 on timeout.
    task automatic wait_ack(input string tag, input int limit, output int cyc);
        cyc = 0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (ack != 2'b00) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int cyc;
    int acc;
    logic [11:0] exp_bcd;

    initial begin
        rst    = 1'b1;
        req    = 2'b00;
        number = 16'h0000;

        // 1: reset state, then 255 on requester 0
        do_reset();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_digits", 32'({hundreds, tens, ones}), 32'h000);
        req = 2'b01;
        number[7:0] = 8'd255;
        tick();
        chk("t1_busy", 32'(busy), 32'd1);
        wait_ack("t1", 20, cyc);
        chk("t1_latency", 32'(cyc), 32'd8);
        req = 2'b00;
        chk("t1_ack", 32'(ack), 32'h1);
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_busy_done", 32'(busy), 32'd0);
        chk("t1_gid", 32'(grant_id), 32'd0);
        chk("t1_digits", 32'({hundreds, tens, ones}), 32'h255);
        tick();
        chk("t1_ack_fall", 32'(ack), 32'd0);
        chk("t1_valid_fall", 32'(valid), 32'd0);
        chk("t1_digits_hold", 32'({hundreds, tens, ones}), 32'h255);

        // 2: simultaneous requests, RR gives 0 then 1 ten cycles later
        do_reset();
        req = 2'b11;
        number = {8'd7, 8'd123};
        wait_ack("t2a", 20, cyc);
        chk("t2a_latency", 32'(cyc), 32'd9);
        chk("t2a_ack", 32'(ack), 32'h1);
        chk("t2a_gid", 32'(grant_id), 32'd0);
        chk("t2a_digits", 32'({hundreds, tens, ones}), 32'h123);
        req = 2'b10;
        wait_ack("t2b", 20, cyc);
        chk("t2b_period", 32'(cyc), 32'd10);
        chk("t2b_ack", 32'(ack), 32'h2);
        chk("t2b_gid", 32'(grant_id), 32'd1);
        chk("t2b_digits", 32'({hundreds, tens, ones}), 32'h007);
        req = 2'b00;

        // 3: both held forever, grants alternate every 10 cycles
        do_reset();
        req = 2'b11;
        number = {8'd42, 8'd42};
        for (int k = 0; k < 4; k++) begin
            wait_ack("t3", 20, cyc);
            chk("t3_period", 32'(cyc), (k == 0) ? 32'd9 : 32'd10);
            chk("t3_gid", 32'(grant_id), 32'(k % 2));
            chk("t3_ack", 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("t3_digits", 32'({hundreds, tens, ones}), 32'h042);
        end
        req = 2'b00;
        tick();
        tick();

        // 4: full operand sweep on requester 1
        do_reset();
        req = 2'b10;
        number = 16'h0000;
        for (int n = 0; n < 256; n++) begin
            wait_ack("t4", 20, cyc);
            exp_bcd = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
            chk($sformatf("t4_n%0d", n), 32'({hundreds, tens, ones}), 32'(exp_bcd));
            if (n < 255) number[15:8] = 8'(n + 1);
        end
        chk("t4_gid", 32'(grant_id), 32'd1);
        req = 2'b00;
        tick();
        tick();

        // 5: reset during the 4th CONV cycle aborts, then a normal conversion
        do_reset();
        req = 2'b01;
        number = 16'd180;
        tick();
        chk("t5_busy", 32'(busy), 32'd1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        req = 2'b00;
        tick();
        rst = 1'b0;
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_digits", 32'({hundreds, tens, ones}), 32'h000);
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (ack != 2'b00 || valid) acc++;
            tick();
        end
        chk("t5_no_ack", 32'(acc), 32'd0);
        req = 2'b01;
        number[7:0] = 8'd5;
        wait_ack("t5b", 20, cyc);
        chk("t5b_latency", 32'(cyc), 32'd9);
        chk("t5b_ack", 32'(ack), 32'h1);
        chk("t5b_digits", 32'({hundreds, tens, ones}), 32'h005);
        req = 2'b00;

        // 6: operand change and req drop right after grant are ignored
        do_reset();
        req = 2'b01;
        number[7:0] = 8'd64;
        tick();
        number[7:0] = 8'd200;
        req = 2'b00;
        wait_ack("t6", 20, cyc);
        chk("t6_latency", 32'(cyc), 32'd8);
        chk("t6_ack", 32'(ack), 32'h1);
        chk("t6_digits", 32'({hundreds, tens, ones}), 32'h064);
        acc = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy || ack != 2'b00) acc++;
        end
        chk("t6_no_restart", 32'(acc), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
